vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised raster timing generator, successor to the fixed 1024x768@60 timing block.
//  Every porch, sync width and polarity is a parameter, and a pixel clock-enable lets one
//  system clock drive lower pixel rates. Adds data-enable, line-start and frame-start strobes.
//  Sits at the head of the VGA pipeline and feeds hcount/vcount/blank/sync to the draw stages.
// PARAMETERS
//  CNT_W     11    width of hcount/vcount
//  H_ACTIVE  1024  visible pixels per line
//  H_FP      24    horizontal front porch, pixels
//  H_SYNC    136   horizontal sync width, pixels
//  H_BP      160   horizontal back porch, pixels
//  V_ACTIVE  768   visible lines per frame
//  V_FP      3     vertical front porch, lines
//  V_SYNC    6     vertical sync width, lines
//  V_BP      29    vertical back porch, lines
//  HSYNC_POL 1     asserted level of hsync (1 = active-high)
//  VSYNC_POL 1     asserted level of vsync
// PORTS
//  clk          in   1      system clock; all logic on rising edge
//  rst_n        in   1      synchronous reset, active-low
//  ce           in   1      pixel enable; the raster advances only on edges where ce=1
//  hcount       out  CNT_W  current pixel column, 0..H_TOTAL-1
//  vcount       out  CNT_W  current line, 0..V_TOTAL-1
//  hblnk        out  1      1 when hcount >= H_ACTIVE
//  vblnk        out  1      1 when vcount >= V_ACTIVE
//  hsync        out  1      HSYNC_POL when hcount in [H_SYNC_START, H_SYNC_END)
//  vsync        out  1      VSYNC_POL when vcount in [V_SYNC_START, V_SYNC_END)
//  de           out  1      ~hblnk & ~vblnk
//  line_start   out  1      one-clk strobe when hcount becomes 0
//  frame_start  out  1      one-clk strobe when (hcount,vcount) becomes (0,0)
// BEHAVIOUR
//  - Derived: H_SYNC_START=H_ACTIVE+H_FP, H_SYNC_END=H_SYNC_START+H_SYNC,
//    H_TOTAL=H_SYNC_END+H_BP; V_* are formed the same way. Elaboration fails if any
//    width parameter is 0 or if H_TOTAL or V_TOTAL exceeds 2**CNT_W.
//  - All outputs are registered. hblnk/vblnk/hsync/vsync/de always match the hcount/vcount
//    values presented in the same cycle, with no skew between count and flags.
//  - rst_n=0 at an edge: hcount=H_TOTAL-1, vcount=V_TOTAL-1, hblnk=1, vblnk=1,
//    hsync=~HSYNC_POL, vsync=~VSYNC_POL, de=0, line_start=0, frame_start=0.
//    Reset takes priority over ce and applies mid-frame with the same values.
//  - Edge with ce=1: hcount <= (hcount==H_TOTAL-1) ? 0 : hcount+1. On that wrap only,
//    vcount <= (vcount==V_TOTAL-1) ? 0 : vcount+1. All flags update on the same edge.
//  - Edge with ce=0: counts and level flags hold; line_start and frame_start drop to 0.
//  - line_start is 1 only in the clk cycle following a ce edge that loaded hcount=0.
//    frame_start is the same, qualified by vcount=0. Each strobe is exactly 1 clk wide
//    for any ce duty.
//  - The first ce edge after reset release yields (0,0), line_start=1, frame_start=1, de=1.
//  - No internal state beyond the counters and output registers. The block is
//    free-running, with no stall or handshake other than ce.
// TESTING
//  - Default params, ce=1, reset for 3 clk: first frame_start 1 clk after release; period
//    between frame_starts = 1344*806 = 1083264 clk; hsync high for hcount 1048..1183.
//  - Default params: vsync high exactly for vcount 771..776, vblnk for 768..805; de=0
//    whenever hcount>=1024; the flags match the counts in the same cycle.
//  - Small mode (H 16/2/3/2, V 8/1/2/1, HSYNC_POL=0, VSYNC_POL=0), ce=1: H_TOTAL=23,
//    V_TOTAL=12; hsync low for hcount 18..20; vsync low for vcount 9..10.
//  - Small mode, ce pulsed 1-of-4: counts advance every 4th clk; line_start and
//    frame_start are 1 clk wide; frame period = 23*12*4 = 1104 clk.
//  - Drop rst_n at hcount=500/vcount=300 while ce=1: next cycle shows the reset values;
//    the first ce after release gives (0,0) with frame_start=1.
//  - Counter wrap: at (22,11) in small mode, the next ce gives (0,0) with both strobes; at
//    (22,5) it gives (0,6) with line_start=1 and frame_start=0.

Source files
------------

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_timing_gen                                               |
// | Description : Parametrised raster timing generator with pixel clock-enable, |
// |               registered counts, blank/sync/de flags and line/frame strobes.|
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module vga_timing_gen #(
    parameter int CNT_W     = 11,
    parameter int H_ACTIVE  = 1024,
    parameter int H_FP      = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BP      = 160,
    parameter int V_ACTIVE  = 768,
    parameter int V_FP      = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 29,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hblnk,
    output logic             vblnk,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line_start,
    output logic             frame_start
);

    // Derived raster geometry
    localparam int c_h_sync_start = H_ACTIVE + H_FP;
    localparam int c_h_sync_end   = c_h_sync_start + H_SYNC;
    localparam int c_h_total      = c_h_sync_end + H_BP;
    localparam int c_v_sync_start = V_ACTIVE + V_FP;
    localparam int c_v_sync_end   = c_v_sync_start + V_SYNC;
    localparam int c_v_total      = c_v_sync_end + V_BP;

    // Width-matched compare constants; all are below 2**CNT_W once the checks pass
    localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_h_act  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_h_ss   = CNT_W'(c_h_sync_start);
    localparam logic [CNT_W-1:0] c_h_se   = CNT_W'(c_h_sync_end);
    localparam logic [CNT_W-1:0] c_h_last = CNT_W'(c_h_total - 1);
    localparam logic [CNT_W-1:0] c_v_act  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_v_ss   = CNT_W'(c_v_sync_start);
    localparam logic [CNT_W-1:0] c_v_se   = CNT_W'(c_v_sync_end);
    localparam logic [CNT_W-1:0] c_v_last = CNT_W'(c_v_total - 1);

    // Refuse to build a raster with a zero-sized region or counters too narrow for it
    generate
        if (CNT_W < 1 || CNT_W > 31 ||
            H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_width
            $error("vga_timing_gen: every width parameter must be non-zero");
        end
        if (c_h_total > (1 << CNT_W) || c_v_total > (1 << CNT_W)) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
        end
    endgenerate

    logic [CNT_W-1:0] r_hcount, r_vcount;
    logic             r_hblnk, r_vblnk, r_hsync, r_vsync, r_de;
    logic             r_line_start, r_frame_start;

    logic [CNT_W-1:0] w_h_nxt, w_v_nxt;
    logic             w_hblnk, w_vblnk, w_hsync, w_vsync;

    // Next raster position and the flags that belong to it, so flags never skew from counts
    always_comb begin
        w_h_nxt = r_hcount;
        w_v_nxt = r_vcount;
        if (ce) begin
            if (r_hcount == c_h_last) begin
                w_h_nxt = '0;
                w_v_nxt = (r_vcount == c_v_last) ? '0 : r_vcount + c_one;
            end else begin
                w_h_nxt = r_hcount + c_one;
            end
        end
        w_hblnk = (w_h_nxt >= c_h_act);
        w_vblnk = (w_v_nxt >= c_v_act);
        w_hsync = (w_h_nxt >= c_h_ss && w_h_nxt < c_h_se) ? HSYNC_POL : ~HSYNC_POL;
        w_vsync = (w_v_nxt >= c_v_ss && w_v_nxt < c_v_se) ? VSYNC_POL : ~VSYNC_POL;
    end

    // Output registers; reset parks the raster on the last pixel so the first ce lands on (0,0)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hcount      <= c_h_last;
            r_vcount      <= c_v_last;
            r_hblnk       <= 1'b1;
            r_vblnk       <= 1'b1;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_de          <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hcount      <= w_h_nxt;
            r_vcount      <= w_v_nxt;
            r_hblnk       <= w_hblnk;
            r_vblnk       <= w_vblnk;
            r_hsync       <= w_hsync;
            r_vsync       <= w_vsync;
            r_de          <= ~w_hblnk & ~w_vblnk;
            r_line_start  <= ce & (w_h_nxt == '0);
            r_frame_start <= ce & (w_h_nxt == '0) & (w_v_nxt == '0);
        end
    end

    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign hblnk       = r_hblnk;
    assign vblnk       = r_vblnk;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vga_timing_gen                                            |
// | Description : Directed/table-driven bench for vga_timing_gen, default and  |
// |               small raster geometries.                                    |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Default-geometry instance (1344 x 806 total), ce tied high
    logic        rst_n_d = 1'b0;
    logic        ce_d    = 1'b1;
    logic [10:0] hc_d, vc_d;
    logic        hb_d, vb_d, hs_d, vs_d, de_d, ls_d, fs_d;

    vga_timing_gen dut_d (
        .clk(clk), .rst_n(rst_n_d), .ce(ce_d),
        .hcount(hc_d), .vcount(vc_d), .hblnk(hb_d), .vblnk(vb_d),
        .hsync(hs_d), .vsync(vs_d), .de(de_d),
        .line_start(ls_d), .frame_start(fs_d)
    );

    // Small-geometry instance: H 16/2/3/2 (23 total), V 8/1/2/1 (12 total), low-active syncs
    logic        rst_n_s = 1'b0;
    logic        ce_s    = 1'b0;
    logic [4:0]  hc_s, vc_s;
    logic        hb_s, vb_s, hs_s, vs_s, de_s, ls_s, fs_s;

    vga_timing_gen #(
        .CNT_W(5), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut_s (
        .clk(clk), .rst_n(rst_n_s), .ce(ce_s),
        .hcount(hc_s), .vcount(vc_s), .hblnk(hb_s), .vblnk(vb_s),
        .hsync(hs_s), .vsync(vs_s), .de(de_s),
        .line_start(ls_s), .frame_start(fs_s)
    );

    // Hand-derived flag expectations {hblnk, vblnk, hsync, vsync, de}
    function automatic logic [4:0] flags_s(input int h, input int v);
        logic hb, vb, hs, vs;
        hb = (h >= 16);
        vb = (v >= 8);
        hs = !(h >= 18 && h <= 20);
        vs = !(v >= 9 && v <= 10);
        return {hb, vb, hs, vs, !hb && !vb};
    endfunction

    function automatic logic [4:0] flags_d(input int h, input int v);
        logic hb, vb, hs, vs;
        hb = (h >= 1024);
        vb = (v >= 768);
        hs = (h >= 1048 && h <= 1183);
        vs = (v >= 771 && v <= 776);
        return {hb, vb, hs, vs, !hb && !vb};
    endfunction

    task automatic chk_s(input string name, input int eh, input int ev, input bit els, input bit efs);
        logic [4:0] gf, ef;
        gf = {hb_s, vb_s, hs_s, vs_s, de_s};
        ef = flags_s(eh, ev);
        n_cmp++;
        if (int'(hc_s) != eh || int'(vc_s) != ev || ls_s != els || fs_s != efs || gf != ef) begin
            n_bad++;
            $display("FAIL %s: got h=%0d v=%0d ls=%0b fs=%0b flags=%05b, want h=%0d v=%0d ls=%0b fs=%0b flags=%05b",
                     name, hc_s, vc_s, ls_s, fs_s, gf, eh, ev, els, efs, ef);
        end
    endtask

    task automatic chk_d(input string name, input int eh, input int ev, input bit els, input bit efs);
        logic [4:0] gf, ef;
        gf = {hb_d, vb_d, hs_d, vs_d, de_d};
        ef = flags_d(eh, ev);
        n_cmp++;
        if (int'(hc_d) != eh || int'(vc_d) != ev || ls_d != els || fs_d != efs || gf != ef) begin
            n_bad++;
            $display("FAIL %s: got h=%0d v=%0d ls=%0b fs=%0b flags=%05b, want h=%0d v=%0d ls=%0b fs=%0b flags=%05b",
                     name, hc_d, vc_d, ls_d, fs_d, gf, eh, ev, els, efs, ef);
        end
    endtask

    // Small-raster reference state, advanced once per clock
    int mh, mv;
    bit mls, mfs;

    task automatic model_s(input bit r, input bit c);
        if (!r) begin
            mh = 22; mv = 11; mls = 0; mfs = 0;
        end else if (c) begin
            if (mh == 22) begin
                mh = 0;
                mv = (mv == 11) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            mls = (mh == 0);
            mfs = (mh == 0) && (mv == 0);
        end else begin
            mls = 0; mfs = 0;
        end
    endtask

    task automatic step_s(input bit r, input bit c);
        rst_n_s = r;
        ce_s    = c;
        @(posedge clk);
        #1;
        model_s(r, c);
    endtask

    typedef struct {
        string name;
        bit    rst_n;
        bit    ce;
        int    h;
        int    v;
        bit    ls;
        bit    fs;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int fs_t[$];
        int dh, dv;

        // ---------------- default geometry ----------------
        repeat (3) @(posedge clk);
        #1;
        chk_d("d_reset", 1343, 805, 0, 0);
        rst_n_d = 1'b1;
        @(posedge clk);
        #1;
        chk_d("d_first", 0, 0, 1, 1);
        dh = 0; dv = 0;
        for (int i = 0; i < 3 * 1344 + 8; i++) begin
            @(posedge clk);
            #1;
            if (dh == 1343) begin dh = 0; dv = dv + 1; end
            else dh = dh + 1;
            chk_d("d_run", dh, dv, dh == 0, dh == 0 && dv == 0);
        end

        // ---------------- small geometry: directed table ----------------
        tbl[0] = '{"s_reset",       0, 1, 22, 11, 0, 0};
        tbl[1] = '{"s_reset_ce0",   0, 0, 22, 11, 0, 0};
        tbl[2] = '{"s_rel_hold",    1, 0, 22, 11, 0, 0};
        tbl[3] = '{"s_first_ce",    1, 1,  0,  0, 1, 1};
        tbl[4] = '{"s_ce0_drop",    1, 0,  0,  0, 0, 0};
        tbl[5] = '{"s_adv1",        1, 1,  1,  0, 0, 0};
        tbl[6] = '{"s_adv2",        1, 1,  2,  0, 0, 0};
        tbl[7] = '{"s_mid_reset",   0, 1, 22, 11, 0, 0};
        tbl[8] = '{"s_after_reset", 1, 1,  0,  0, 1, 1};
        for (int i = 0; i < 9; i++) begin
            step_s(tbl[i].rst_n, tbl[i].ce);
            chk_s(tbl[i].name, tbl[i].h, tbl[i].v, tbl[i].ls, tbl[i].fs);
        end

        // Model now tracks (0,0); run a full frame and beyond with ce=1
        mh = 0; mv = 0;
        for (int i = 0; i < 23 * 12 + 30; i++) begin
            step_s(1, 1);
            chk_s("s_run", mh, mv, mls, mfs);
        end

        // Line wrap at (22,5)
        for (int i = 0; i < 400 && !(mh == 22 && mv == 5); i++) begin
            step_s(1, 1);
            chk_s("s_seek5", mh, mv, mls, mfs);
        end
        step_s(1, 1);
        chk_s("s_wrap_line", 0, 6, 1, 0);

        // Frame wrap at (22,11)
        for (int i = 0; i < 400 && !(mh == 22 && mv == 11); i++) begin
            step_s(1, 1);
            chk_s("s_seek11", mh, mv, mls, mfs);
        end
        step_s(1, 1);
        chk_s("s_wrap_frame", 0, 0, 1, 1);

        // ce pulsed 1-of-4 after a fresh reset; frame period must be 23*12*4
        step_s(0, 1);
        chk_s("s_reset2", 22, 11, 0, 0);
        for (int cyc = 0; cyc < 2300; cyc++) begin
            step_s(1, (cyc % 4) == 0);
            chk_s("s_ce4", mh, mv, mls, mfs);
            if (fs_s) fs_t.push_back(cyc);
        end
        n_cmp++;
        if (fs_t.size() < 2) begin
            n_bad++;
            $display("FAIL s_period: got %0d frame_start pulses, want at least 2", fs_t.size());
        end else if (fs_t[1] - fs_t[0] != 1104) begin
            n_bad++;
            $display("FAIL s_period: got %0d clk, want 1104 clk", fs_t[1] - fs_t[0]);
        end

        // Mid-frame reset while ce=1, then recovery
        step_s(0, 1);
        chk_s("s_mid_reset2", 22, 11, 0, 0);
        step_s(1, 1);
        chk_s("s_recover", 0, 0, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
